// File: rtl/mux_obuf_pkg.sv
// Shared router definitions: flit type encodings, enable constants, default widths
// and the framing-state encoding used by mux_obuf.
package mux_obuf_pkg;

    typedef enum logic [1:0] {
        TYPE_NONE = 2'b00,
        TYPE_HEAD = 2'b01,
        TYPE_DATA = 2'b10,
        TYPE_TAIL = 2'b11
    } flit_type_e;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam int FLIT_W_DEF = 66;
    localparam int VCH_W_DEF  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } frame_state_e;

    function automatic flit_type_e flit_type(input logic [1:0] type_bits);
        return flit_type_e'(type_bits);
    endfunction

endpackage

// File: rtl/mux_obuf_fifo.sv
// First-word-fall-through flit FIFO: storage, pointers, occupancy and the
// iready/ovalid handshake flags. No empty-bypass, so write-to-read latency is one cycle.
module mux_obuf_fifo
    import mux_obuf_pkg::*;
#(
    parameter int FLIT_W = FLIT_W_DEF,
    parameter int VCH_W  = VCH_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_req,
    input  logic [FLIT_W-1:0]       wr_data,
    input  logic [VCH_W-1:0]        wr_vch,
    input  logic                    rd_req,
    output logic [FLIT_W-1:0]       rd_data,
    output logic [VCH_W-1:0]        rd_vch,
    output logic                    iready,
    output logic                    ovalid,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [FLIT_W-1:0] data_mem_r [DEPTH];
    logic [VCH_W-1:0]  vch_mem_r  [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic              wr_fire_s;
    logic              rd_fire_s;

    assign iready    = (level_r != FULL_LVL);
    assign ovalid    = (level_r != {LW{1'b0}});
    assign level     = level_r;
    assign wr_fire_s = wr_req & iready;
    assign rd_fire_s = rd_req & ovalid;

    // Head-of-FIFO view; forced to zero while empty so reset shows a clean bus.
    always_comb begin
        rd_data = {FLIT_W{1'b0}};
        rd_vch  = {VCH_W{1'b0}};
        if (ovalid) begin
            rd_data = data_mem_r[rd_ptr_r];
            rd_vch  = vch_mem_r[rd_ptr_r];
        end else begin
            rd_data = {FLIT_W{1'b0}};
            rd_vch  = {VCH_W{1'b0}};
        end
    end

    // Flit storage write port.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            data_mem_r[wr_ptr_r] <= wr_data;
            vch_mem_r[wr_ptr_r]  <= wr_vch;
        end
    end

    // Pointers wrap modulo DEPTH; level moves only when exactly one side fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (wr_fire_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_fire_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_fire_s, rd_fire_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/mux_obuf.sv
// Output flit buffer behind the 2:1 router mux: FWFT FIFO plus packet framing checker.
// Optional statistics counters are enabled with `MUX_OBUF_STATS_EN.
module mux_obuf
    import mux_obuf_pkg::*;
#(
    parameter int FLIT_W = FLIT_W_DEF,
    parameter int VCH_W  = VCH_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FLIT_W-1:0]       idata,
    input  logic                    ivalid,
    input  logic [VCH_W-1:0]        ivch,
    output logic                    iready,
    output logic [FLIT_W-1:0]       odata,
    output logic                    ovalid,
    output logic [VCH_W-1:0]        ovch,
    input  logic                    oready,
    output logic                    err_frame,
    output logic [$clog2(DEPTH):0]  level
`ifdef MUX_OBUF_STATS_EN
    ,
    output logic [31:0]             flit_cnt,
    output logic [31:0]             pkt_cnt
`endif
);

    flit_type_e   flit_type_s;
    logic         wr_req_s;
    logic         wr_fire_s;
    logic         vc_match_s;
    logic         pkt_done_s;
    frame_state_e state_r;
    logic [VCH_W-1:0] vc_lock_r;

    assign flit_type_s = flit_type(idata[FLIT_W-1:FLIT_W-2]);
    assign wr_req_s    = ivalid & (flit_type_s != TYPE_NONE);
    assign wr_fire_s   = wr_req_s & iready;
    assign vc_match_s  = (ivch == vc_lock_r);
    assign pkt_done_s  = wr_fire_s & (state_r == ST_BODY)
                       & (flit_type_s == TYPE_TAIL) & vc_match_s;

    mux_obuf_fifo #(
        .FLIT_W (FLIT_W),
        .VCH_W  (VCH_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_req  (wr_req_s),
        .wr_data (idata),
        .wr_vch  (ivch),
        .rd_req  (oready),
        .rd_data (odata),
        .rd_vch  (ovch),
        .iready  (iready),
        .ovalid  (ovalid),
        .level   (level)
    );

    // Framing checker; a HEAD inside a packet restarts it even on a different VC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            vc_lock_r <= {VCH_W{1'b0}};
            err_frame <= DISABLE;
        end else begin
            err_frame <= DISABLE;
            if (wr_fire_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (flit_type_s == TYPE_HEAD) begin
                            state_r   <= ST_BODY;
                            vc_lock_r <= ivch;
                        end else begin
                            err_frame <= ENABLE;
                        end
                    end
                    ST_BODY: begin
                        if (flit_type_s == TYPE_HEAD) begin
                            err_frame <= ENABLE;
                            vc_lock_r <= ivch;
                        end else if (!vc_match_s) begin
                            err_frame <= ENABLE;
                        end else if (flit_type_s == TYPE_TAIL) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_BODY;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef MUX_OBUF_STATS_EN
    // Accepted-flit and completed-packet counters, free-running with natural wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_cnt <= 32'd0;
            pkt_cnt  <= 32'd0;
        end else begin
            if (wr_fire_s) begin
                flit_cnt <= flit_cnt + 32'd1;
            end
            if (pkt_done_s) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_stats_s;
    assign unused_stats_s = pkt_done_s;
`endif

endmodule

// File: tb/tb_mux_obuf.sv
// Self-checking bench for mux_obuf: directed scenarios plus random traffic, all
// compared cycle by cycle against a queue-based reference of the buffer and framing rules.
module tb_mux_obuf;
    import mux_obuf_pkg::*;

    localparam int FW    = 66;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] idata;
    logic          ivalid;
    logic [0:0]    ivch;
    logic          iready;
    logic [FW-1:0] odata;
    logic          ovalid;
    logic [0:0]    ovch;
    logic          oready;
    logic          err_frame;
    logic [2:0]    level;
`ifdef MUX_OBUF_STATS_EN
    logic [31:0]   flit_cnt;
    logic [31:0]   pkt_cnt;
`endif

    mux_obuf #(.FLIT_W(FW), .VCH_W(1), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .idata     (idata),
        .ivalid    (ivalid),
        .ivch      (ivch),
        .iready    (iready),
        .odata     (odata),
        .ovalid    (ovalid),
        .ovch      (ovch),
        .oready    (oready),
        .err_frame (err_frame),
        .level     (level)
`ifdef MUX_OBUF_STATS_EN
        ,
        .flit_cnt  (flit_cnt),
        .pkt_cnt   (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: the buffer is just a bounded queue; framing is "inside a packet on VC lock".
    logic [FW-1:0] q_data[$];
    logic [0:0]    q_vch[$];
    bit            in_pkt;
    logic [0:0]    lock_vc;
    int            n_flits;
    int            n_pkts;
    int            n_err;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t);
        logic [FW-1:0] f;
        f = {t, $urandom(), $urandom()};
        return f;
    endfunction

    function automatic void model_reset();
        q_data.delete();
        q_vch.delete();
        in_pkt  = 1'b0;
        lock_vc = 1'b0;
        n_flits = 0;
        n_pkts  = 0;
    endfunction

    // One clock: drive at negedge, check FWFT view, predict, check post-edge state.
    task automatic step(input logic [FW-1:0] d, input logic iv, input logic [0:0] vc,
                        input logic ordy, output bit acc);
        int  sz;
        bit  wr;
        bit  rd;
        bit  exp_err;
        logic [1:0] t;
        idata = d; ivalid = iv; ivch = vc; oready = ordy;
        #1;
        sz = q_data.size();
        chk("ovalid", FW'(ovalid), FW'(sz != 0));
        chk("iready", FW'(iready), FW'(sz != DEPTH));
        if (sz != 0) begin
            chk("odata", odata, q_data[0]);
            chk("ovch", FW'(ovch), FW'(q_vch[0]));
        end
        t  = d[FW-1 -: 2];
        wr = iv && (t != 2'b00) && (sz < DEPTH);
        rd = (sz != 0) && ordy;
        exp_err = 1'b0;
        if (rd) begin
            void'(q_data.pop_front());
            void'(q_vch.pop_front());
        end
        if (wr) begin
            q_data.push_back(d);
            q_vch.push_back(vc);
            n_flits++;
            if (!in_pkt) begin
                if (t == 2'b01) begin
                    in_pkt = 1'b1; lock_vc = vc;
                end else begin
                    exp_err = 1'b1;
                end
            end else if (t == 2'b01) begin
                exp_err = 1'b1; lock_vc = vc;
            end else if (vc != lock_vc) begin
                exp_err = 1'b1;
            end else if (t == 2'b11) begin
                in_pkt = 1'b0; n_pkts++;
            end
        end
        if (exp_err) n_err++;
        @(posedge clk);
        #1;
        chk("err_frame", FW'(err_frame), FW'(exp_err));
        chk("level", FW'(level), FW'(q_data.size()));
        acc = wr;
        @(negedge clk);
    endtask

    // Offer one flit until accepted, with a bounded number of attempts.
    task automatic send(input logic [1:0] t, input logic [0:0] vc, input logic ordy_toggle,
                        inout logic ordy);
        bit acc;
        logic [FW-1:0] f;
        int tries;
        f = mk(t);
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 16) begin
            step(f, 1'b1, vc, ordy, acc);
            if (ordy_toggle) ordy = ~ordy;
            tries++;
        end
        chk("send_timeout", FW'(acc), FW'(1'b1));
    endtask

    initial begin
        bit   acc;
        logic ordy;
        int   err_before;
        n_err = 0;
        model_reset();
        idata = '0; ivalid = 1'b0; ivch = 1'b0; oready = 1'b0;

        // 1. reset held for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ovalid", FW'(ovalid), FW'(0));
        chk("rst_iready", FW'(iready), FW'(1));
        chk("rst_level", FW'(level), FW'(0));
        chk("rst_err", FW'(err_frame), FW'(0));
        chk("rst_odata", odata, FW'(0));

        // 2. stream HEAD, 20 DATA, TAIL with oready high
        ordy = 1'b1;
        err_before = n_err;
        send(2'b01, 1'b0, 1'b0, ordy);
        repeat (20) send(2'b10, 1'b0, 1'b0, ordy);
        send(2'b11, 1'b0, 1'b0, ordy);
        step(mk(2'b00), 1'b0, 1'b0, 1'b1, acc);
        chk("stream_noerr", FW'(n_err), FW'(err_before));
`ifdef MUX_OBUF_STATS_EN
        chk("stream_flit_cnt", FW'(flit_cnt), FW'(22));
        chk("stream_pkt_cnt", FW'(pkt_cnt), FW'(1));
`endif

        // 3. fill with oready low, then drain while still offering
        step(mk(2'b01), 1'b1, 1'b0, 1'b0, acc);
        for (int i = 0; i < 5; i++) step(mk(2'b10), 1'b1, 1'b0, 1'b0, acc);
        chk("full_level", FW'(level), FW'(DEPTH));
        chk("full_iready", FW'(iready), FW'(0));
        for (int i = 0; i < 8; i++) step(mk(2'b10), 1'b1, 1'b0, 1'b1, acc);
        step(mk(2'b11), 1'b1, 1'b0, 1'b1, acc);
        repeat (6) step(mk(2'b00), 1'b0, 1'b0, 1'b1, acc);

        // 4. ten packets across pointer wrap with oready toggling
        ordy = 1'b0;
        for (int p = 0; p < 10; p++) begin
            send(2'b01, 1'(p), 1'b1, ordy);
            repeat (20) send(2'b10, 1'(p), 1'b1, ordy);
            send(2'b11, 1'(p), 1'b1, ordy);
        end
        repeat (6) step(mk(2'b00), 1'b0, 1'b0, 1'b1, acc);
        chk("wrap_drained", FW'(q_data.size()), FW'(0));

        // 5. framing errors: DATA in IDLE, HEAD in packet, wrong-VC DATA
        err_before = n_err;
        step(mk(2'b10), 1'b1, 1'b0, 1'b1, acc);
        step(mk(2'b01), 1'b1, 1'b0, 1'b1, acc);
        step(mk(2'b01), 1'b1, 1'b0, 1'b1, acc);
        step(mk(2'b10), 1'b1, 1'b1, 1'b1, acc);
        step(mk(2'b11), 1'b1, 1'b0, 1'b1, acc);
        step(mk(2'b00), 1'b0, 1'b0, 1'b1, acc);
        chk("frame_err_count", FW'(n_err - err_before), FW'(3));

        // 6. NONE flits leave everything alone, then reset with flits buffered
        step(mk(2'b00), 1'b1, 1'b1, 1'b0, acc);
        step(mk(2'b01), 1'b1, 1'b0, 1'b0, acc);
        step(mk(2'b10), 1'b1, 1'b0, 1'b0, acc);
        step(mk(2'b00), 1'b1, 1'b1, 1'b0, acc);
        step(mk(2'b10), 1'b1, 1'b0, 1'b0, acc);
        chk("none_level", FW'(level), FW'(3));
        rst = 1'b1;
        #1;
        chk("midrst_ovalid", FW'(ovalid), FW'(0));
        chk("midrst_level", FW'(level), FW'(0));
        chk("midrst_iready", FW'(iready), FW'(1));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(mk(2'b10), 1'b1, 1'b0, 1'b1, acc);

        // random traffic against the reference
        for (int i = 0; i < 400; i++) begin
            step(mk(2'($urandom_range(3))), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), acc);
        end
`ifdef MUX_OBUF_STATS_EN
        chk("rand_flit_cnt", FW'(flit_cnt), FW'(n_flits));
        chk("rand_pkt_cnt", FW'(pkt_cnt), FW'(n_pkts));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
